// File: rtl/seq_guess_pkg.sv
// seq_guess_pkg
// Shared definitions for the sequence-guessing engine.
//   seq_default  : default sequence, f(s) = (3*s + 1) mod 2**data_w
//   group_start  : state with its in-group offset bits cleared
//   CNT_SAT      : saturation limit of the 8-bit pass/error counters
package seq_guess_pkg;

    localparam logic [7:0] CNT_SAT = 8'hFF;

    function automatic int unsigned seq_default(input int unsigned s,
                                                input int unsigned data_w);
        return (3 * s + 1) % (32'd1 << data_w);
    endfunction

    // group must be a power of two.
    function automatic int unsigned group_start(input int unsigned s,
                                                input int unsigned group);
        return s & ~(group - 1);
    endfunction

endpackage

// File: rtl/seq_func.sv
// seq_func
// Combinational map from sequence state to the expected digit. Swap this
// module to change the sequence for a different exercise variant.
// Ports:
//   state     in  STATE_W  current sequence state
//   exp_digit out DATA_W   digit the user must enter in this state
module seq_func
    import seq_guess_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    output logic [DATA_W-1:0]  exp_digit
);

    always_comb begin
        exp_digit = DATA_W'(seq_default(32'(state), unsigned'(DATA_W)));
    end

endmodule

// File: rtl/seq_guess_engine.sv
// seq_guess_engine
// Sequence-guessing automaton feeding the seven-segment display path.
// A correct digit advances the state; a wrong one rolls back to the start
// of the current group of GROUP states. The upper display half shows the
// expected digits of the current group, the lower half the entry history.
// Optional macro SEQ_GUESS_ERRLIMIT_EN: MAX_ERR wrong entries within a group
// send the state back to 0 and clear the history.
// Handshake: load is a one-cycle strobe with no back-pressure; data is
// sampled on every clock edge where load is high, and every load is honoured.
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   load, data  entry strobe and entered digit
//   display     {upper half (expected view), lower half (history)}
//   display_en  per-digit enables, upper DIGITS bits for the upper half
//   state_o     current state (also the debug view of the automaton)
//   done        one-cycle pulse after the last state is answered correctly
//   pass_cnt    completed sequences, saturating
//   err_cnt     wrong entries since reset, saturating
module seq_guess_engine
    import seq_guess_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int STATE_W = 4,
    parameter int GROUP   = 4,
    parameter int DIGITS  = 4,
    parameter int MAX_ERR = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [DATA_W-1:0]          data,
    output logic [2*DIGITS*DATA_W-1:0] display,
    output logic [2*DIGITS-1:0]        display_en,
    output logic [STATE_W-1:0]         state_o,
    output logic                       done,
    output logic [7:0]                 pass_cnt,
    output logic [7:0]                 err_cnt
);

    localparam int GB = $clog2(GROUP);
    localparam int HW = DIGITS * DATA_W;

    logic [STATE_W-1:0] state_q, state_d;
    logic               upd_q, upd_d;
    logic               done_q, done_d;
    logic [7:0]         pass_q, pass_d;
    logic [7:0]         err_q, err_d;
    logic [HW-1:0]      up_q, up_d, lo_q, lo_d;
    logic [DIGITS-1:0]  up_en_q, up_en_d, lo_en_q, lo_en_d;
    logic [DATA_W-1:0]  exp_digit;
    logic [STATE_W-1:0] grp_base;

`ifdef SEQ_GUESS_ERRLIMIT_EN
    localparam int EW = $clog2(MAX_ERR + 1);
    logic [EW-1:0] grp_err_q, grp_err_d;
`endif

    seq_func #(
        .DATA_W  (DATA_W),
        .STATE_W (STATE_W)
    ) u_seq_func (
        .state     (state_q),
        .exp_digit (exp_digit)
    );

    assign grp_base = STATE_W'(group_start(32'(state_q), unsigned'(GROUP)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            upd_q   <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= '0;
            err_q   <= '0;
            up_q    <= '0;
            lo_q    <= '0;
            up_en_q <= '0;
            lo_en_q <= '0;
`ifdef SEQ_GUESS_ERRLIMIT_EN
            grp_err_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            up_q    <= up_d;
            lo_q    <= lo_d;
            up_en_q <= up_en_d;
            lo_en_q <= lo_en_d;
`ifdef SEQ_GUESS_ERRLIMIT_EN
            grp_err_q <= grp_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        up_d    = up_q;
        up_en_d = up_en_q;
        lo_d    = lo_q;
        lo_en_d = lo_en_q;
`ifdef SEQ_GUESS_ERRLIMIT_EN
        grp_err_d = grp_err_q;
`endif

        // Upper half follows the pre-load state; a group start restarts
        // the view so it only ever shows the current group.
        if (upd_q) begin
            if (state_q[GB-1:0] == '0) begin
                up_d    = {{(HW-DATA_W){1'b0}}, exp_digit};
                up_en_d = {{(DIGITS-1){1'b0}}, 1'b1};
            end else begin
                up_d    = {up_q[HW-DATA_W-1:0], exp_digit};
                up_en_d = {up_en_q[DIGITS-2:0], 1'b1};
            end
        end

        if (load) begin
            upd_d   = 1'b1;
            lo_d    = {lo_q[HW-DATA_W-1:0], data};
            lo_en_d = {lo_en_q[DIGITS-2:0], 1'b1};
            if (data == exp_digit) begin
                if (state_q == '1) begin
                    state_d = '0;
                    done_d  = 1'b1;
                    if (pass_q != CNT_SAT) pass_d = pass_q + 8'd1;
                end else begin
                    state_d = state_q + 1'b1;
                end
`ifdef SEQ_GUESS_ERRLIMIT_EN
                // Last state of a group answered: the next entry is in a new group.
                if (state_q[GB-1:0] == '1) grp_err_d = '0;
`endif
            end else begin
                if (err_q != CNT_SAT) err_d = err_q + 8'd1;
`ifdef SEQ_GUESS_ERRLIMIT_EN
                if (grp_err_q + 1'b1 == EW'(MAX_ERR)) begin
                    state_d   = '0;
                    grp_err_d = '0;
                    lo_d      = '0;
                    lo_en_d   = '0;
                end else begin
                    state_d   = grp_base;
                    grp_err_d = grp_err_q + 1'b1;
                end
`else
                state_d = grp_base;
`endif
            end
        end
    end

    // Outputs
    always_comb begin
        display    = {up_q, lo_q};
        display_en = {up_en_q, lo_en_q};
        state_o    = state_q;
        done       = done_q;
        pass_cnt   = pass_q;
        err_cnt    = err_q;
    end

endmodule

// File: tb/tb_seq_guess_engine.sv
// tb_seq_guess_engine
// Directed bench for seq_guess_engine with default parameters.
// Expected values are hand-computed constants and a hand-written table of
// the default sequence.
module tb_seq_guess_engine;

    logic        clk;
    logic        rst;
    logic        load;
    logic [3:0]  data;
    logic [31:0] display;
    logic [7:0]  display_en;
    logic [3:0]  state_o;
    logic        done;
    logic [7:0]  pass_cnt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] seq_tbl [16] = '{4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd3, 4'd6,
                                 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14};

    seq_guess_engine dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .display    (display),
        .display_en (display_en),
        .state_o    (state_o),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .err_cnt    (err_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drivers: called at a negedge, return at the next negedge.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_digit(input logic [3:0] d);
        load = 1'b1;
        data = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        data = '0;
        repeat (2) @(negedge clk);
        check("rst_display", display, 32'h0);
        check("rst_en", 32'(display_en), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_cnts", {16'h0, pass_cnt, err_cnt}, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_display", display, 32'h0001_0000);
        check("first_en", 32'(display_en), 32'h10);

        // Two correct entries
        load_digit(4'd1);
        load_digit(4'd4);
        check("two_state", 32'(state_o), 32'd2);
        check("two_lower", 32'(display[15:0]), 32'h0014);
        check("two_lower_en", 32'(display_en[3:0]), 32'h3);
        repeat (2) @(negedge clk);
        check("two_upper", 32'(display[31:16]), 32'h0147);
        check("two_upper_en", 32'(display_en[7:4]), 32'h7);

        // Wrong entry at state 5 rolls back to 4
        do_reset();
        for (int i = 0; i < 5; i++) load_digit(seq_tbl[i]);
        check("s5_state", 32'(state_o), 32'd5);
        load_digit(4'd9);
        check("wrong_state", 32'(state_o), 32'd4);
        check("wrong_err", 32'(err_cnt), 32'd1);
        @(negedge clk);
        check("wrong_upper", 32'(display[31:16]), 32'h000D);
        check("wrong_upper_en", 32'(display_en[7:4]), 32'h1);
        check("wrong_lower", 32'(display[15:0]), 32'h7AD9);

        // Full sequence through the scoreboard queue
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(seq_tbl[i]);
        for (int i = 0; i < 16; i++) begin
            load_digit(exp_q.pop_front());
            if (i < 15) check($sformatf("seq_state_%0d", i), 32'(state_o), 32'(i + 1));
        end
        check("full_done_hi", 32'(done), 32'd1);
        check("full_state", 32'(state_o), 32'd0);
        check("full_pass", 32'(pass_cnt), 32'd1);
        @(negedge clk);
        check("full_done_lo", 32'(done), 32'd0);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_upper", 32'(display[31:16]), 32'h0001);
        check("full_upper_en", 32'(display_en[7:4]), 32'h1);

        // Three wrong entries within one group
        do_reset();
        for (int i = 0; i < 6; i++) load_digit(seq_tbl[i]);
        check("s6_state", 32'(state_o), 32'd6);
        repeat (3) load_digit(4'd15);
        check("lim_err", 32'(err_cnt), 32'd3);
`ifdef SEQ_GUESS_ERRLIMIT_EN
        check("lim_state", 32'(state_o), 32'd0);
        check("lim_lower", 32'(display[15:0]), 32'h0000);
        check("lim_lower_en", 32'(display_en[3:0]), 32'h0);
`else
        check("lim_state", 32'(state_o), 32'd4);
        check("lim_lower", 32'(display[15:0]), 32'h0FFF);
        check("lim_lower_en", 32'(display_en[3:0]), 32'hF);
`endif

        // Asynchronous reset at state 9
        do_reset();
        for (int i = 0; i < 9; i++) load_digit(seq_tbl[i]);
        check("s9_state", 32'(state_o), 32'd9);
        done_cnt = 0;
        #2 rst = 1'b1;
        #1;
        check("arst_display", display, 32'h0);
        check("arst_en", 32'(display_en), 32'h0);
        check("arst_state", 32'(state_o), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_upper", 32'(display[31:16]), 32'h0001);
        check("arst_upper_en", 32'(display_en), 32'h10);
        check("arst_no_done", 32'(done_cnt), 32'd0);

        // Error counter saturation
        do_reset();
        repeat (260) load_digit(4'd0);
        check("sat_err", 32'(err_cnt), 32'd255);
        check("sat_state", 32'(state_o), 32'd0);
        check("sat_pass", 32'(pass_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_guess_engine.md
Name: seq_guess_engine

Overview:
Parametrised sequence-guessing automaton for the board's seven-segment display path. The user enters digits with `load`/`data`. A correct digit advances the state. A wrong digit rolls the state back to the start of its group of GROUP states; with the optional feature, repeated errors return it to state 0. The left display half shows the expected digits of the current group. The right half shows the entered-digit history. The block feeds the existing display multiplexer/driver and adds a completion pulse, a pass counter and an error counter.

Parameters:
DATA_W, 4, width of one digit (entered data and expected value).
STATE_W, 4, state counter width; the sequence has 2**STATE_W steps.
GROUP, 4, states per group; power of two, 2..2**STATE_W.
DIGITS, 4, digits per display half; must be >= GROUP.
MAX_ERR, 3, wrong entries within one group before a full return to state 0 (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
load  in  1  one-cycle strobe; `data` is sampled on this clock edge
data  in  DATA_W  entered digit
display  out  2*DIGITS*DATA_W  digit bus; upper half = expected-digit view, lower half = entered history; digit 0 is least significant
display_en  out  2*DIGITS  per-digit enable; upper DIGITS bits belong to the upper half
state_o  out  STATE_W  current state
done  out  1  one-cycle pulse when the last state is answered correctly
pass_cnt  out  8  completed full sequences, saturating at 255
err_cnt  out  8  wrong entries since reset, saturating at 255

Behaviour:
- Reset values: state=0, display=0, display_en=0, done=0, pass_cnt=0, err_cnt=0. Internal flag upd=1, so the first expected digit is shown one clock after reset release. Internal group error counter grp_err=0.
- Expected digit: exp = seq_func(state). This is combinational from the registered state.
- Upper-half update (every clock with upd=1):
  - If state mod GROUP == 0: upper display = exp in digit 0, zeros elsewhere; upper enables = 1 in bit 0 only.
  - Otherwise: shift upper digits left by one and insert exp at digit 0; shift upper enables left and insert 1.
  - Then clear upd.
- Load (every clock with load=1):
  - Shift the lower half left by one digit and insert `data`; shift lower enables left and insert 1. Older digits drop off the top.
  - Correct (data == exp):
    - state <= state+1.
    - If state == 2**STATE_W-1: state wraps to 0, done=1 for one cycle, pass_cnt+1 (saturating).
  - Wrong:
    - state <= state with its low log2(GROUP) bits cleared.
    - err_cnt+1 (saturating).
  - Set upd=1.
- Load and upd in the same clock: the upper half uses exp of the pre-load state; upd is set again by the load; both updates happen. Load therefore takes precedence in setting upd.
- Latency: load at edge N → state_o and the lower display valid after N. The upper display shows the new exp after edge N+1.
- Load during upd=1 with no gap is legal; every load is honoured; no back-pressure.
- Reset mid-sequence: all registers return to reset values immediately; no done pulse.

Optional Feature:
Macro: SEQ_GUESS_ERRLIMIT_EN.
- Enabled:
  - grp_err counts wrong entries and clears on every correct entry that crosses into a new group.
  - When a wrong entry makes grp_err reach MAX_ERR: state <= 0 instead of the group start; grp_err <= 0; the lower half is cleared to 0 with enables 0, instead of shifting.
- Disabled:
  - No grp_err register exists.
  - A wrong entry always rolls back to the group start only.

Decomposition:
- Package seq_guess_pkg holds:
  - the default sequence constant function f(s) = (3*s+1) mod 2**DATA_W;
  - the group-mask helper;
  - the saturation limit constant for the 8-bit counters.
- One sub-module, seq_func: a combinational map from state to expected digit, built on the package function. It is replaceable per exercise variant.

Test Plan:
- Reset release → after 1 clk, upper display = 0x0001, display_en = 0x10, state_o = 0.
- Load 1, then 4 (defaults) → state_o = 2; lower display = 0x0014, en[3:0] = 0x3; two clocks after the last load, upper display = 0x0147, en[7:4] = 0x7.
- Reach state 5 (correct entries 1, 4, 7, 10, 13), then load 9 → state_o = 4, err_cnt = 1, upper display = 0x000D, en[7:4] = 0x1.
- Enter all 16 correct digits → done pulses exactly once, in the cycle after the last load; pass_cnt = 1; state_o = 0; upper display = 0x0001.
- With SEQ_GUESS_ERRLIMIT_EN: at state 6, enter three wrong digits → after the 3rd, state_o = 0, lower display = 0, display_en[3:0] = 0, err_cnt = 3.
- Assert rst asynchronously between clock edges at state 9 → all outputs 0 immediately, no done pulse; the first clock after release shows 0x0001 in the upper half.
